// File: rtl/irq_pkg.sv
// Shared types for the interrupt arbiter: FSM state encoding.
package irq_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ENC_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ENC_REQ     = 2'd1;
  localparam logic [STATE_W-1:0] ENC_SERVICE = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = ENC_IDLE,
    ST_REQ     = ENC_REQ,
    ST_SERVICE = ENC_SERVICE
  } irq_state_e;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational winner select: first set request bit searching upward from start, wrapping at NSRC.
module irq_prio_sel #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NSRC-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic            grant_vld_c,
  output logic [IDW-1:0]  grant_id_c
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    sum         = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      sum = {1'b0, start} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NSRC)) begin
        sum = sum - (IDW+1)'(NSRC);
      end
      idx = sum[IDW-1:0];
      if (!grant_vld_c && req[idx]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = idx;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched pending bits, IDLE/REQ/SERVICE handshake with the CPU.
// Define IRQ_RR_EN for round-robin arbitration; default build is fixed priority (lowest index).
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  input  logic [NSRC-1:0] src_en,
  input  logic            irq_take,
  input  logic            irq_done,
  output logic            irq_req,
  output logic [IDW-1:0]  irq_id,
  output logic            irq_active,
  output logic [NSRC-1:0] pending
);

  irq_state_e      state_q, state_d;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr_mask;
  logic [NSRC-1:0] pending_d;
  logic [NSRC-1:0] req_vec;
  logic [IDW-1:0]  id_d;
  logic            req_d;
  logic            active_d;
  logic            take_ok;
  logic [IDW-1:0]  start_ptr;
  logic            win_vld;
  logic [IDW-1:0]  win_id;

  assign rise    = src_irq & ~src_q;
  assign req_vec = pending & src_en;

  irq_prio_sel #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio_sel (
    .req         (req_vec),
    .start       (start_ptr),
    .grant_vld_c (win_vld),
    .grant_id_c  (win_id)
  );

`ifdef IRQ_RR_EN
  logic [IDW-1:0] rr_ptr;

  // Search restarts just past the last taken source.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (take_ok) begin
      rr_ptr <= (irq_id == IDW'(NSRC-1)) ? '0 : irq_id + IDW'(1);
    end
  end

  assign start_ptr = rr_ptr;
`else
  assign start_ptr = '0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    id_d     = irq_id;
    req_d    = 1'b0;
    active_d = 1'b0;
    take_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_REQ;
          id_d    = win_id;
          req_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (irq_take) begin
          take_ok  = 1'b1;
          state_d  = ST_SERVICE;
          active_d = 1'b1;
        end else if (!src_en[irq_id]) begin
          state_d = ST_IDLE;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (irq_done) begin
          state_d = ST_IDLE;
        end else begin
          active_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh edge on the source being cleared keeps its pending bit set.
  always_comb begin
    clr_mask  = take_ok ? (NSRC'(1) << irq_id) : '0;
    pending_d = (pending & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      pending    <= '0;
      irq_id     <= '0;
      irq_req    <= 1'b0;
      irq_active <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_irq;
      pending    <= pending_d;
      irq_id     <= id_d;
      irq_req    <= req_d;
      irq_active <= active_d;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboarded bench for irq_arbiter: event-level reference model, directed scenarios, then random traffic.
module tb_irq_arbiter;

  localparam int unsigned NSRC = 4;
  localparam int unsigned IDW  = 2;

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] src_irq;
  logic [NSRC-1:0] src_en;
  logic            irq_take;
  logic            irq_done;
  logic            irq_req;
  logic [IDW-1:0]  irq_id;
  logic            irq_active;
  logic [NSRC-1:0] pending;

  int total = 0;
  int bad   = 0;

  irq_arbiter #(.NSRC(NSRC), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .src_en     (src_en),
    .irq_take   (irq_take),
    .irq_done   (irq_done),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_active (irq_active),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: which source is being presented / serviced (-1 = none).
  bit [NSRC-1:0] m_pend;
  bit [NSRC-1:0] m_seen;
  int            m_pres;
  int            m_serv;
  int            m_last;
  int            exp_q[$];

  function automatic int pick(input bit [NSRC-1:0] v, input int start);
    for (int k = 0; k < int'(NSRC); k++) begin
      int id;
      id = (start + k) % int'(NSRC);
      if (v[id]) return id;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit [NSRC-1:0] clr;
    int w;
    int start;
    if (!rst) begin
      m_pend = '0;
      m_seen = '0;
      m_pres = -1;
      m_serv = -1;
      m_last = -1;
      exp_q.delete();
    end else begin
      clr = '0;
`ifdef IRQ_RR_EN
      start = (m_last + 1) % int'(NSRC);
`else
      start = 0;
`endif
      if (m_serv >= 0) begin
        if (irq_done) m_serv = -1;
      end else if (m_pres >= 0) begin
        if (irq_take) begin
          clr[m_pres] = 1'b1;
          m_last = m_pres;
          m_serv = m_pres;
          m_pres = -1;
        end else if (!src_en[m_pres]) begin
          m_pres = -1;
        end
      end else begin
        w = pick(m_pend & src_en, start);
        if (w >= 0) begin
          m_pres = w;
          exp_q.push_back(w);
        end
      end
      m_pend = (m_pend & ~clr) | (src_irq & ~m_seen);
      m_seen = src_irq;
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on each new presentation.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    int e;
    if (rst) begin
      chk("pending", 32'(pending), 32'(m_pend));
      chk("irq_req", 32'(irq_req), 32'(m_pres >= 0));
      chk("irq_active", 32'(irq_active), 32'(m_serv >= 0));
      chk("req_active_excl", 32'(irq_req & irq_active), 32'd0);
      if (m_serv >= 0) chk("service_id", 32'(irq_id), 32'(m_serv));
      if (irq_req && !prev_req) begin
        chk("grant_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("grant_id", 32'(irq_id), 32'(e));
        end
      end
      prev_req = irq_req;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_take();
    irq_take = 1'b1;
    cyc();
    irq_take = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    cyc();
    irq_done = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !irq_req; i++) cyc();
    chk("wait_req", 32'(irq_req), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (pending == '0 && !irq_req && !irq_active) break;
      if (irq_req) pulse_take();
      else if (irq_active) pulse_done();
      else cyc();
    end
    chk("drain_pending", 32'(pending), 32'd0);
    chk("drain_active", 32'(irq_active), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst      = 1'b0;
    src_irq  = '0;
    src_en   = '1;
    irq_take = 1'b0;
    irq_done = 1'b0;
    #12;
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_active", 32'(irq_active), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    cyc();

    // Single source: latency and take.
    src_irq = 4'b0010;
    cyc();
    chk("s1_pending", 32'(pending), 32'b0010);
    chk("s1_req_early", 32'(irq_req), 32'd0);
    cyc();
    chk("s1_req", 32'(irq_req), 32'd1);
    chk("s1_id", 32'(irq_id), 32'd1);
    pulse_take();
    chk("s1_pend_clr", 32'(pending), 32'd0);
    chk("s1_active", 32'(irq_active), 32'd1);
    cyc();
    pulse_done();
    src_irq = '0;
    cyc();

    // Two simultaneous sources.
    src_irq = 4'b1001;
    wait_req();
    chk("s2_first", 32'(irq_id), 32'd0);
    pulse_take();
    pulse_done();
    wait_req();
    chk("s2_second", 32'(irq_id), 32'd3);
    pulse_take();
    pulse_done();
    src_irq = '0;
    cyc();

    // Enable withdrawn while presenting.
    src_irq = 4'b0100;
    wait_req();
    chk("s3_id", 32'(irq_id), 32'd2);
    src_en = 4'b1011;
    cyc();
    chk("s3_req_drop", 32'(irq_req), 32'd0);
    chk("s3_pend_kept", 32'(pending[2]), 32'd1);
    cyc();
    cyc();
    chk("s3_still_off", 32'(irq_req), 32'd0);
    src_en = 4'b1111;
    wait_req();
    chk("s3_repres", 32'(irq_id), 32'd2);
    pulse_take();
    pulse_done();
    src_irq = '0;
    cyc();

    // New edge during service: no nesting.
    src_irq = 4'b0001;
    wait_req();
    pulse_take();
    src_irq = 4'b1001;
    cyc();
    chk("s4_pend3", 32'(pending), 32'b1000);
    cyc();
    cyc();
    chk("s4_no_nest", 32'(irq_req), 32'd0);
    pulse_done();
    wait_req();
    chk("s4_next", 32'(irq_id), 32'd3);
    pulse_take();
    pulse_done();
    src_irq = '0;
    cyc();

    // Sources 0 and 1 re-edged during every service.
    src_irq = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      wait_req();
`ifdef IRQ_RR_EN
      chk("grant_seq", 32'(irq_id), 32'(k % 2));
`else
      chk("grant_seq", 32'(irq_id), 32'd0);
`endif
      pulse_take();
      src_irq = '0;
      cyc();
      src_irq = 4'b0011;
      cyc();
      pulse_done();
    end
    src_irq = '0;
    drain();

    // Asynchronous reset during service.
    src_irq = 4'b0001;
    wait_req();
    pulse_take();
    cyc();
    chk("s6_in_service", 32'(irq_active), 32'd1);
    rst = 1'b0;
    #1;
    chk("s6_async_active", 32'(irq_active), 32'd0);
    chk("s6_async_req", 32'(irq_req), 32'd0);
    chk("s6_async_pending", 32'(pending), 32'd0);
    chk("s6_async_id", 32'(irq_id), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("s6_first_edge_req", 32'(irq_req), 32'd0);
    chk("s6_first_edge_pend", 32'(pending), 32'b0001);
    cyc();
    chk("s6_second_edge_req", 32'(irq_req), 32'd1);
    chk("s6_second_edge_id", 32'(irq_id), 32'd0);
    pulse_take();
    pulse_done();
    src_irq = '0;
    cyc();

    // Random traffic, including stray take/done pulses.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < int'(NSRC); b++) begin
        if ($urandom_range(0, 5) == 0) src_irq[b] = ~src_irq[b];
      end
      src_en   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      irq_take = irq_req    ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      irq_done = irq_active ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      cyc();
    end
    irq_take = 1'b0;
    irq_done = 1'b0;
    src_irq  = '0;
    src_en   = '1;
    cyc();
    drain();
    cyc();
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
